fifo_rd_ctrl: RTL and testbench
===============================

FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

Interface
REQ-001 The block SHALL have one clock, rclk, and an asynchronous, active-low reset, rrst_n.
REQ-002 Parameter DSIZE, default 8, SHALL set the data width in bits.
REQ-003 Parameter STALL_MAX, default 255, SHALL set the backpressure cycle count that triggers the stall flag (range 1..255).
REQ-004 Port rclk, input, 1 bit: read-domain clock; all state updates on its rising edge.
REQ-005 Port rrst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 Port rempty, input, 1 bit: FIFO empty flag from the read-pointer logic.
REQ-007 Port rdata, input, DSIZE bits: FIFO head word, first-word-fall-through, valid whenever rempty=0.
REQ-008 Port rinc, output, 1 bit: FIFO read-increment (pop) request.
REQ-009 Port m_data, output, DSIZE bits: downstream stream data.
REQ-010 Port m_valid, output, 1 bit: m_data holds a word.
REQ-011 Port m_ready, input, 1 bit: downstream accepts the word.
REQ-012 Port rd_count, output, 16 bits: words delivered downstream.
REQ-013 Port stall_flag, output, 1 bit: downstream has stalled for STALL_MAX cycles.

Function
REQ-014 The block SHALL hold 0..2 words in two registers, main and skid; occupancy states are EMPTY (0), ONE (1) and TWO (2).
REQ-015 rinc SHALL equal (!rempty && occ!=TWO), combinationally; it SHALL NOT depend on m_ready.
REQ-016 push SHALL equal rinc; when push=1, rdata SHALL be captured on the same rclk edge.
REQ-017 pop SHALL equal (m_valid && m_ready).
REQ-018 m_valid SHALL equal (occ!=EMPTY), and m_data SHALL always be the main register.
REQ-019 In EMPTY, push SHALL load main and move to ONE.
REQ-020 In ONE, push and pop together SHALL load main with rdata and stay in ONE.
REQ-021 In ONE, push alone SHALL load skid and move to TWO.
REQ-022 In ONE, pop alone SHALL move to EMPTY.
REQ-023 In TWO, pop SHALL move skid into main and go to ONE; with no pop the state SHALL hold.
REQ-024 Latency: a word present with rempty=0 at edge N SHALL appear on m_data with m_valid=1 immediately after edge N.
REQ-025 Sustained throughput SHALL be 1 word/cycle while rempty=0 and m_ready=1.
REQ-026 Words SHALL be delivered in FIFO order, with no loss or duplication under any m_ready pattern.
REQ-027 m_data SHALL stay stable while m_valid=1 and m_ready=0.
REQ-028 If rempty rises while occupancy is nonzero, held words SHALL still drain and rinc SHALL remain 0.
REQ-029 rd_count SHALL increment by 1 on each pop, modulo 2^16 (0xFFFF wraps to 0x0000).
REQ-030 An 8-bit stall counter SHALL increment each cycle with m_valid=1 and m_ready=0, saturating at STALL_MAX.
REQ-031 The stall counter SHALL clear on any cycle with pop=1 or m_valid=0.
REQ-032 stall_flag SHALL be registered and set on the edge where the stall counter reaches STALL_MAX.
REQ-033 stall_flag SHALL stay set until the next pop edge, then clear.

Reset
REQ-034 rrst_n=0 SHALL immediately force occ=EMPTY, m_valid=0, m_data=0, rd_count=0, stall counter=0 and stall_flag=0; rinc SHALL follow (!rempty).
REQ-035 Reset asserted mid-transfer SHALL discard main and skid contents; words already popped from the FIFO are lost by design.
REQ-036 After rrst_n deasserts, the first rising edge SHALL operate normally.

Verification
REQ-037 Reset: rrst_n=0 with rempty=0 -> m_valid=0, rd_count=0, stall_flag=0 and rinc=1 during reset.
REQ-038 Streaming: FIFO holds 0x01..0x08, m_ready=1 -> m_data reads 0x01..0x08 on 8 consecutive cycles and rd_count=8.
REQ-039 Backpressure: m_ready=0 with 4 words queued -> exactly 2 rinc pulses and occ=TWO; m_ready=1 -> data appears in order with no gap.
REQ-040 Stall: STALL_MAX=4, m_valid=1, m_ready=0 -> stall_flag rises after the 4th stalled edge and clears on the edge after m_ready=1.
REQ-041 Wrap: rd_count preloaded to 0xFFFE by 65534 pops, then 2 pops -> 0xFFFF, then 0x0000.
REQ-042 Mid-op reset: occ=TWO, rrst_n pulsed low -> m_valid=0 at once; a subsequent word 0xA5 is delivered normally.

Source files
------------

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller: pulls words from a FWFT FIFO into a two-entry main/skid
// buffer and presents them as a valid/ready stream, with a pop counter and stall detector.
module fifo_rd_ctrl #(
    parameter int DSIZE     = 8,
    parameter int STALL_MAX = 255
) (
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic             rempty,
    input  logic [DSIZE-1:0] rdata,
    output logic             rinc,
    output logic [DSIZE-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [15:0]      rd_count,
    output logic             stall_flag
);

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] TWO   = 2'd2;

    localparam logic [7:0] STALL_LIMIT = 8'(STALL_MAX);

    logic [1:0]       occ_reg, occ_next;
    logic [DSIZE-1:0] main_reg, main_next;
    logic [DSIZE-1:0] skid_reg, skid_next;
    logic [15:0]      rd_count_reg;
    logic [7:0]       stall_cnt_reg, stall_cnt_next;
    logic             stall_flag_reg, stall_flag_next;
    logic             push, pop, stalled;

    // The FIFO is drained only while there is room; downstream readiness never gates it.
    assign rinc    = !rempty && (occ_reg != TWO);
    assign push    = rinc;
    assign m_valid = (occ_reg != EMPTY);
    assign pop     = m_valid && m_ready;
    assign stalled = m_valid && !m_ready;

    assign m_data     = main_reg;
    assign rd_count   = rd_count_reg;
    assign stall_flag = stall_flag_reg;

    always_comb begin
        occ_next  = occ_reg;
        main_next = main_reg;
        skid_next = skid_reg;
        case (occ_reg)
            EMPTY: begin
                if (push) begin
                    main_next = rdata;
                    occ_next  = ONE;
                end
            end
            ONE: begin
                if (push && pop) begin
                    main_next = rdata;
                end else if (push) begin
                    skid_next = rdata;
                    occ_next  = TWO;
                end else if (pop) begin
                    occ_next  = EMPTY;
                end
            end
            TWO: begin
                // push is impossible here, so only a pop can change the state
                if (pop) begin
                    main_next = skid_reg;
                    occ_next  = ONE;
                end
            end
            default: occ_next = EMPTY;
        endcase
    end

    always_comb begin
        stall_cnt_next = stall_cnt_reg;
        if (pop || !m_valid) begin
            stall_cnt_next = 8'd0;
        end else if (stall_cnt_reg != STALL_LIMIT) begin
            stall_cnt_next = stall_cnt_reg + 8'd1;
        end

        stall_flag_next = stall_flag_reg;
        if (pop) begin
            stall_flag_next = 1'b0;
        end else if (stalled && (stall_cnt_next == STALL_LIMIT)) begin
            stall_flag_next = 1'b1;
        end
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            occ_reg        <= EMPTY;
            main_reg       <= '0;
            skid_reg       <= '0;
            rd_count_reg   <= 16'd0;
            stall_cnt_reg  <= 8'd0;
            stall_flag_reg <= 1'b0;
        end else begin
            occ_reg        <= occ_next;
            main_reg       <= main_next;
            skid_reg       <= skid_next;
            stall_cnt_reg  <= stall_cnt_next;
            stall_flag_reg <= stall_flag_next;
            if (pop) begin
                rd_count_reg <= rd_count_reg + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl: a queue models the FWFT FIFO, a vector table
// covers streaming and backpressure, hand sequences cover reset, stall and wrap.
module tb_fifo_rd_ctrl;

    logic        rclk;
    logic        rrst_n;
    logic        rempty;
    logic [7:0]  rdata;
    logic        rinc;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_ready;
    logic [15:0] rd_count;
    logic        stall_flag;

    fifo_rd_ctrl #(.DSIZE(8), .STALL_MAX(4)) dut (
        .rclk      (rclk),
        .rrst_n    (rrst_n),
        .rempty    (rempty),
        .rdata     (rdata),
        .rinc      (rinc),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .rd_count  (rd_count),
        .stall_flag(stall_flag)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    typedef struct {
        int          pre_n;
        logic [7:0]  pre_base;
        logic        rdy;
        logic        exp_valid;
        logic [7:0]  exp_data;
        logic        exp_rinc;
        logic [15:0] exp_cnt;
        logic        exp_stall;
    } vec_t;

    vec_t       vecs[17];
    logic [7:0] fifo_q[$];
    int         total;
    int         bad;
    int         n_takes;
    int         takes_mark;
    int         order_err;

    task automatic refresh();
        rempty = (fifo_q.size() == 0);
        rdata  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    endtask

    task automatic load(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) fifo_q.push_back(base + 8'(i));
        refresh();
    endtask

    // One clock: sample the pop request before the edge, retire the word after it.
    task automatic tick();
        logic take;
        @(negedge rclk);
        take = rinc;
        if (take) n_takes++;
        @(posedge rclk);
        #1;
        if (take && fifo_q.size() != 0) fifo_q.delete(0);
        refresh();
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        total   = 0;
        bad     = 0;
        n_takes = 0;
        takes_mark = 0;
        order_err  = 0;

        // streaming 0x01..0x08 with m_ready held high
        vecs[0]  = '{8, 8'h01, 1'b1, 1'b1, 8'h01, 1'b1, 16'd0,  1'b0};
        vecs[1]  = '{0, 8'h00, 1'b1, 1'b1, 8'h02, 1'b1, 16'd1,  1'b0};
        vecs[2]  = '{0, 8'h00, 1'b1, 1'b1, 8'h03, 1'b1, 16'd2,  1'b0};
        vecs[3]  = '{0, 8'h00, 1'b1, 1'b1, 8'h04, 1'b1, 16'd3,  1'b0};
        vecs[4]  = '{0, 8'h00, 1'b1, 1'b1, 8'h05, 1'b1, 16'd4,  1'b0};
        vecs[5]  = '{0, 8'h00, 1'b1, 1'b1, 8'h06, 1'b1, 16'd5,  1'b0};
        vecs[6]  = '{0, 8'h00, 1'b1, 1'b1, 8'h07, 1'b1, 16'd6,  1'b0};
        vecs[7]  = '{0, 8'h00, 1'b1, 1'b1, 8'h08, 1'b0, 16'd7,  1'b0};
        vecs[8]  = '{0, 8'h00, 1'b1, 1'b0, 8'h08, 1'b0, 16'd8,  1'b0};
        // backpressure: four words queued, m_ready low for four edges, then released
        vecs[9]  = '{4, 8'h21, 1'b0, 1'b1, 8'h21, 1'b1, 16'd8,  1'b0};
        vecs[10] = '{0, 8'h00, 1'b0, 1'b1, 8'h21, 1'b0, 16'd8,  1'b0};
        vecs[11] = '{0, 8'h00, 1'b0, 1'b1, 8'h21, 1'b0, 16'd8,  1'b0};
        vecs[12] = '{0, 8'h00, 1'b0, 1'b1, 8'h21, 1'b0, 16'd8,  1'b0};
        vecs[13] = '{0, 8'h00, 1'b1, 1'b1, 8'h22, 1'b1, 16'd9,  1'b0};
        vecs[14] = '{0, 8'h00, 1'b1, 1'b1, 8'h23, 1'b1, 16'd10, 1'b0};
        vecs[15] = '{0, 8'h00, 1'b1, 1'b1, 8'h24, 1'b0, 16'd11, 1'b0};
        vecs[16] = '{0, 8'h00, 1'b1, 1'b0, 8'h24, 1'b0, 16'd12, 1'b0};

        // reset with a word waiting in the FIFO
        rrst_n  = 1'b0;
        m_ready = 1'b0;
        load(1, 8'h11);
        #3;
        chk("rst_valid", 32'(m_valid), 32'd0);
        chk("rst_data",  32'(m_data),  32'h00);
        chk("rst_count", 32'(rd_count), 32'd0);
        chk("rst_stall", 32'(stall_flag), 32'd0);
        chk("rst_rinc",  32'(rinc), 32'd1);
        $display("reset: m_valid=%0d rd_count=%0d rinc=%0d", m_valid, rd_count, rinc);
        fifo_q.delete();
        refresh();
        tick();
        tick();
        rrst_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            if (vecs[i].pre_n != 0) load(vecs[i].pre_n, vecs[i].pre_base);
            if (i == 9) takes_mark = n_takes;
            m_ready = vecs[i].rdy;
            tick();
            $display("vec %0d: rdy=%0d m_valid=%0d m_data=%02h rinc=%0d rd_count=%0d stall=%0d",
                     i, vecs[i].rdy, m_valid, m_data, rinc, rd_count, stall_flag);
            chk($sformatf("vec%0d_valid", i), 32'(m_valid),    32'(vecs[i].exp_valid));
            chk($sformatf("vec%0d_data", i),  32'(m_data),     32'(vecs[i].exp_data));
            chk($sformatf("vec%0d_rinc", i),  32'(rinc),       32'(vecs[i].exp_rinc));
            chk($sformatf("vec%0d_count", i), 32'(rd_count),   32'(vecs[i].exp_cnt));
            chk($sformatf("vec%0d_stall", i), 32'(stall_flag), 32'(vecs[i].exp_stall));
            if (i == 12) chk("bp_rinc_pulses", 32'(n_takes - takes_mark), 32'd2);
        end
        chk("all_words_pulled", 32'(n_takes), 32'd12);

        // stall detector with STALL_MAX=4
        m_ready = 1'b0;
        load(1, 8'h31);
        tick();
        for (int s = 1; s <= 4; s++) begin
            tick();
            $display("stall edge %0d: stall=%0d m_data=%02h", s, stall_flag, m_data);
            chk($sformatf("stall_e%0d_flag", s), 32'(stall_flag), (s == 4) ? 32'd1 : 32'd0);
            chk($sformatf("stall_e%0d_data", s), 32'(m_data), 32'h31);
        end
        tick();
        chk("stall_saturated_flag", 32'(stall_flag), 32'd1);
        m_ready = 1'b1;
        tick();
        $display("stall release: stall=%0d rd_count=%0d", stall_flag, rd_count);
        chk("stall_clear_flag",  32'(stall_flag), 32'd0);
        chk("stall_clear_count", 32'(rd_count),   32'd13);
        chk("stall_clear_valid", 32'(m_valid),    32'd0);

        // reset while both registers are full
        m_ready = 1'b0;
        load(3, 8'h41);
        tick();
        tick();
        chk("midrst_two_rinc", 32'(rinc), 32'd0);
        rrst_n = 1'b0;
        #1;
        $display("mid-op reset: m_valid=%0d m_data=%02h rd_count=%0d", m_valid, m_data, rd_count);
        chk("midrst_valid", 32'(m_valid),  32'd0);
        chk("midrst_data",  32'(m_data),   32'h00);
        chk("midrst_count", 32'(rd_count), 32'd0);
        chk("midrst_rinc",  32'(rinc),     32'd1);
        rrst_n = 1'b1;
        fifo_q.delete();
        load(1, 8'hA5);
        m_ready = 1'b1;
        tick();
        chk("post_rst_valid", 32'(m_valid), 32'd1);
        chk("post_rst_data",  32'(m_data),  32'hA5);
        tick();
        $display("post-reset word: rd_count=%0d", rd_count);
        chk("post_rst_count", 32'(rd_count), 32'd1);

        // rd_count wrap: 65534 streamed pops, then two more
        rrst_n = 1'b0;
        #1;
        rrst_n = 1'b1;
        load(65534, 8'h00);
        for (int n = 1; n <= 65535; n++) begin
            tick();
            if (n <= 65534 && (m_valid !== 1'b1 || m_data !== 8'(n - 1))) order_err++;
        end
        chk("wrap_stream_order", 32'(order_err), 32'd0);
        chk("wrap_pre_count", 32'(rd_count), 32'hFFFE);
        load(2, 8'hB1);
        tick();
        chk("wrap_e1_count", 32'(rd_count), 32'hFFFE);
        tick();
        $display("wrap: rd_count=%04h", rd_count);
        chk("wrap_e2_count", 32'(rd_count), 32'hFFFF);
        chk("wrap_e2_data",  32'(m_data),   32'hB2);
        tick();
        $display("wrap: rd_count=%04h", rd_count);
        chk("wrap_e3_count", 32'(rd_count), 32'h0000);
        chk("wrap_e3_valid", 32'(m_valid),  32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
